// File: rtl/instr_fetch.sv
// -----------------------------------------------------------------------------
// instr_fetch
//   Instruction fetch front end. It issues one word-aligned request at a time
//   to instruction memory and buffers the returned words, with their byte
//   addresses, in a 2-entry FIFO. The head of that FIFO feeds decode. A
//   redirect (PCSrc) flushes the FIFO and restarts fetch at BranchTarget. If a
//   request is still waiting for IReady when the redirect arrives, its response
//   is discarded.
//
// Ports
//   clk           in   clock; all state updates on the rising edge
//   reset         in   synchronous reset, active low
//   PCSrc         in   redirect strobe, valid for one cycle
//   BranchTarget  in   redirect byte address (bits [1:0] ignored)
//   Stall         in   decode cannot take the head instruction this cycle
//   IReq          out  instruction-memory request valid
//   IAddr         out  word-aligned instruction-memory address
//   IReady        in   memory accepts the request, IRdata valid this cycle
//   IRdata        in   returned instruction word
//   InstrValid    out  head instruction present
//   Instr         out  head instruction word (zero when empty)
//   Cond/Op/Funct/Rd  out  decoder fields of the head instruction
//   PCPlus8       out  head byte address + 8 (RESET_PC + 8 when empty)
// -----------------------------------------------------------------------------
module instr_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        PCSrc,
  input  logic [31:0] BranchTarget,
  input  logic        Stall,
  output logic        IReq,
  output logic [31:0] IAddr,
  input  logic        IReady,
  input  logic [31:0] IRdata,
  output logic        InstrValid,
  output logic [31:0] Instr,
  output logic [3:0]  Cond,
  output logic [1:0]  Op,
  output logic [4:0]  Funct,
  output logic [3:0]  Rd,
  output logic [31:0] PCPlus8
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_DROP = 2'd2
  } state_t;

  state_t      state_q, state_d;
  logic        ireq_q, ireq_d;
  logic [31:0] pc_q, pc_d;       // address of the request being issued
  logic [31:0] tgt_q, tgt_d;     // redirected PC held while a response is dropped
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] instr0_q, instr0_d, addr0_q, addr0_d;   // slot 0 is the head
  logic [31:0] instr1_q, instr1_d, addr1_q, addr1_d;

  logic        pop;
  logic        push;
  logic [1:0]  cnt_after_pop;
  logic [31:0] target;

  // Low bits of the branch target are dropped by word alignment.
  logic unused_tgt_bits;
  assign unused_tgt_bits = ^BranchTarget[1:0];

  assign target        = {BranchTarget[31:2], 2'b00};
  assign pop           = (cnt_q != 2'd0) && !Stall;
  assign cnt_after_pop = cnt_q - {1'b0, pop};

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    tgt_d    = tgt_q;
    push     = 1'b0;
    cnt_d    = cnt_q;
    instr0_d = instr0_q;
    addr0_d  = addr0_q;
    instr1_d = instr1_q;
    addr1_d  = addr1_q;

    unique case (state_q)
      S_IDLE: begin
        if (PCSrc) begin
          state_d = S_REQ;
          pc_d    = target;
        end else if (cnt_after_pop < 2'd2) begin
          state_d = S_REQ;
        end
      end
      S_REQ: begin
        if (PCSrc) begin
          if (IReady) begin
            // Response arriving alongside the redirect is on the wrong path.
            pc_d    = target;
            state_d = S_REQ;
          end else begin
            // Request still outstanding: keep IAddr stable, discard later.
            tgt_d   = target;
            state_d = S_DROP;
          end
        end else if (IReady) begin
          push    = 1'b1;
          pc_d    = pc_q + 32'd4;
          // After this push the FIFO holds cnt_after_pop + 1 entries.
          state_d = (cnt_after_pop == 2'd0) ? S_REQ : S_IDLE;
        end
      end
      S_DROP: begin
        if (IReady) begin
          state_d = S_REQ;
          pc_d    = PCSrc ? target : tgt_q;
        end else if (PCSrc) begin
          tgt_d   = target;
        end
      end
      default: state_d = S_IDLE;
    endcase

    // FIFO: pop shifts slot 1 into slot 0, push lands after what remains.
    if (PCSrc) begin
      cnt_d = 2'd0;
    end else begin
      if (pop) begin
        instr0_d = instr1_q;
        addr0_d  = addr1_q;
      end
      if (push) begin
        if (cnt_after_pop == 2'd0) begin
          instr0_d = IRdata;
          addr0_d  = pc_q;
        end else begin
          instr1_d = IRdata;
          addr1_d  = pc_q;
        end
      end
      cnt_d = cnt_after_pop + {1'b0, push};
    end

    ireq_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    instr0_q <= instr0_d;
    addr0_q  <= addr0_d;
    instr1_q <= instr1_d;
    addr1_q  <= addr1_d;
    tgt_q    <= tgt_d;
    if (!reset) begin
      state_q <= S_IDLE;
      ireq_q  <= 1'b0;
      pc_q    <= RESET_PC;
      cnt_q   <= 2'd0;
    end else begin
      state_q <= state_d;
      ireq_q  <= ireq_d;
      pc_q    <= pc_d;
      cnt_q   <= cnt_d;
    end
  end

  assign IReq       = ireq_q;
  assign IAddr      = pc_q;
  assign InstrValid = (cnt_q != 2'd0);
  // Gate the head with valid so stale slot contents never reach decode.
  assign Instr      = InstrValid ? instr0_q : 32'd0;
  assign Cond       = Instr[31:28];
  assign Op         = Instr[27:26];
  assign Funct      = Instr[24:20];
  assign Rd         = Instr[15:12];
  assign PCPlus8    = (InstrValid ? addr0_q : RESET_PC) + 32'd8;

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  localparam logic [31:0] K = 32'hE3A0_5F0F;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        PCSrc = 1'b0;
  logic [31:0] BranchTarget = 32'd0;
  logic        Stall = 1'b0;
  logic        IReady = 1'b0;
  logic [31:0] IRdata;
  logic        IReq;
  logic [31:0] IAddr;
  logic        InstrValid;
  logic [31:0] Instr;
  logic [3:0]  Cond;
  logic [1:0]  Op;
  logic [4:0]  Funct;
  logic [3:0]  Rd;
  logic [31:0] PCPlus8;

  int n_tests = 0;
  int n_fail  = 0;

  instr_fetch #(.RESET_PC(32'h0000_0000)) dut (
    .clk(clk), .reset(reset), .PCSrc(PCSrc), .BranchTarget(BranchTarget),
    .Stall(Stall), .IReq(IReq), .IAddr(IAddr), .IReady(IReady),
    .IRdata(IRdata), .InstrValid(InstrValid), .Instr(Instr), .Cond(Cond),
    .Op(Op), .Funct(Funct), .Rd(Rd), .PCPlus8(PCPlus8)
  );

  always #5 clk = ~clk;

  // Memory model: the word stored at address a is a ^ K.
  assign IRdata = IAddr ^ K;

  function automatic logic [31:0] word(input logic [31:0] a);
    return a ^ K;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b0; PCSrc = 1'b0; Stall = 1'b0; IReady = 1'b1;
    BranchTarget = 32'd0;
    tick(); tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    reset = 1'b0; IReady = 1'b1; Stall = 1'b0; PCSrc = 1'b0;
    tick(); tick();
    n_tests++; if (IReq !== 1'b0) begin n_fail++; $display("FAIL rst_ireq: got %b want 0", IReq); end
    n_tests++; if (InstrValid !== 1'b0) begin n_fail++; $display("FAIL rst_valid: got %b want 0", InstrValid); end
    n_tests++; if (Instr !== 32'd0) begin n_fail++; $display("FAIL rst_instr: got %h want 0", Instr); end
    n_tests++; if (IAddr !== 32'd0) begin n_fail++; $display("FAIL rst_iaddr: got %h want 0", IAddr); end
    n_tests++; if (PCPlus8 !== 32'd8) begin n_fail++; $display("FAIL rst_pcplus8: got %h want 8", PCPlus8); end
  endtask

  task automatic test_stream();
    logic [31:0] e;
    do_reset();
    tick();
    n_tests++; if (IReq !== 1'b1 || IAddr !== 32'd0 || InstrValid !== 1'b0) begin n_fail++;
      $display("FAIL stream_first_req: got ireq=%b addr=%h vld=%b want 1 0 0", IReq, IAddr, InstrValid); end
    tick();
    n_tests++; if (InstrValid !== 1'b1 || Instr !== K || PCPlus8 !== 32'd8 || IAddr !== 32'd4) begin n_fail++;
      $display("FAIL stream_first_word: got vld=%b instr=%h p8=%h addr=%h want 1 %h 8 4", InstrValid, Instr, PCPlus8, IAddr, K); end
    n_tests++; if (Cond !== 4'hE || Op !== 2'b00 || Funct !== 5'h1A || Rd !== 4'h5) begin n_fail++;
      $display("FAIL stream_fields: got cond=%h op=%b funct=%h rd=%h want e 00 1a 5", Cond, Op, Funct, Rd); end
    for (int k = 1; k <= 5; k++) begin
      tick();
      e = 32'(4 * k);
      n_tests++; if (IAddr !== e + 32'd4 || Instr !== word(e) || PCPlus8 !== e + 32'd8 || InstrValid !== 1'b1) begin n_fail++;
        $display("FAIL stream_k%0d: got addr=%h instr=%h p8=%h want %h %h %h", k, IAddr, Instr, PCPlus8, e + 32'd4, word(e), e + 32'd8); end
    end
  endtask

  task automatic test_stall();
    do_reset();
    Stall = 1'b1;
    tick(); tick(); tick();
    n_tests++; if (IReq !== 1'b0 || InstrValid !== 1'b1 || Instr !== word(32'd0) || IAddr !== 32'd8) begin n_fail++;
      $display("FAIL stall_full: got ireq=%b vld=%b instr=%h addr=%h want 0 1 %h 8", IReq, InstrValid, Instr, IAddr, word(32'd0)); end
    tick();
    n_tests++; if (IReq !== 1'b0 || Instr !== word(32'd0)) begin n_fail++;
      $display("FAIL stall_hold: got ireq=%b instr=%h want 0 %h", IReq, Instr, word(32'd0)); end
    Stall = 1'b0;
    tick();
    n_tests++; if (Instr !== word(32'd4) || IReq !== 1'b1 || IAddr !== 32'd8) begin n_fail++;
      $display("FAIL stall_rel1: got instr=%h ireq=%b addr=%h want %h 1 8", Instr, IReq, IAddr, word(32'd4)); end
    tick();
    n_tests++; if (Instr !== word(32'd8) || PCPlus8 !== 32'd16) begin n_fail++;
      $display("FAIL stall_rel2: got instr=%h p8=%h want %h 10", Instr, PCPlus8, word(32'd8)); end
  endtask

  task automatic test_idle_redirect();
    do_reset();
    Stall = 1'b1;
    tick(); tick(); tick();
    PCSrc = 1'b1; BranchTarget = 32'h0000_0041;
    tick();
    PCSrc = 1'b0;
    n_tests++; if (IReq !== 1'b1 || IAddr !== 32'h40 || InstrValid !== 1'b0) begin n_fail++;
      $display("FAIL idle_redirect: got ireq=%b addr=%h vld=%b want 1 40 0", IReq, IAddr, InstrValid); end
  endtask

  task automatic test_drop();
    do_reset();
    for (int i = 0; i < 5; i++) tick();
    n_tests++; if (IAddr !== 32'h10) begin n_fail++; $display("FAIL drop_setup: got %h want 10", IAddr); end
    IReady = 1'b0;
    tick();
    PCSrc = 1'b1; BranchTarget = 32'h0000_0103;
    tick();
    PCSrc = 1'b0;
    n_tests++; if (IReq !== 1'b1 || IAddr !== 32'h10 || InstrValid !== 1'b0) begin n_fail++;
      $display("FAIL drop_hold: got ireq=%b addr=%h vld=%b want 1 10 0", IReq, IAddr, InstrValid); end
    tick();
    n_tests++; if (IAddr !== 32'h10) begin n_fail++; $display("FAIL drop_hold2: got %h want 10", IAddr); end
    IReady = 1'b1;
    tick();
    n_tests++; if (IAddr !== 32'h100 || InstrValid !== 1'b0 || IReq !== 1'b1) begin n_fail++;
      $display("FAIL drop_discard: got addr=%h vld=%b ireq=%b want 100 0 1", IAddr, InstrValid, IReq); end
    tick();
    n_tests++; if (InstrValid !== 1'b1 || Instr !== word(32'h100) || PCPlus8 !== 32'h108) begin n_fail++;
      $display("FAIL drop_target_word: got vld=%b instr=%h p8=%h want 1 %h 108", InstrValid, Instr, PCPlus8, word(32'h100)); end
  endtask

  task automatic test_redirect_hit();
    do_reset();
    tick(); tick(); tick();
    PCSrc = 1'b1; BranchTarget = 32'h0000_0200;
    tick();
    PCSrc = 1'b0;
    n_tests++; if (InstrValid !== 1'b0 || IAddr !== 32'h200 || IReq !== 1'b1) begin n_fail++;
      $display("FAIL hit_flush: got vld=%b addr=%h ireq=%b want 0 200 1", InstrValid, IAddr, IReq); end
    tick();
    n_tests++; if (InstrValid !== 1'b1 || Instr !== word(32'h200) || PCPlus8 !== 32'h208) begin n_fail++;
      $display("FAIL hit_target_word: got vld=%b instr=%h p8=%h want 1 %h 208", InstrValid, Instr, PCPlus8, word(32'h200)); end
  endtask

  task automatic test_wrap();
    do_reset();
    tick(); tick();
    PCSrc = 1'b1; BranchTarget = 32'hFFFF_FFFC;
    tick();
    PCSrc = 1'b0;
    n_tests++; if (IAddr !== 32'hFFFF_FFFC) begin n_fail++; $display("FAIL wrap_setup: got %h want fffffffc", IAddr); end
    tick();
    n_tests++; if (IAddr !== 32'd0 || PCPlus8 !== 32'd4 || Instr !== word(32'hFFFF_FFFC)) begin n_fail++;
      $display("FAIL wrap_pc: got addr=%h p8=%h instr=%h want 0 4 %h", IAddr, PCPlus8, Instr, word(32'hFFFF_FFFC)); end
    tick();
    n_tests++; if (PCPlus8 !== 32'd8 || Instr !== word(32'd0)) begin n_fail++;
      $display("FAIL wrap_next: got p8=%h instr=%h want 8 %h", PCPlus8, Instr, word(32'd0)); end
  endtask

  task automatic test_reset_in_drop();
    do_reset();
    tick(); tick();
    IReady = 1'b0; PCSrc = 1'b1; BranchTarget = 32'h0000_0300;
    tick();
    PCSrc = 1'b0;
    n_tests++; if (IReq !== 1'b1 || IAddr !== 32'd4) begin n_fail++;
      $display("FAIL rdrop_setup: got ireq=%b addr=%h want 1 4", IReq, IAddr); end
    reset = 1'b0;
    tick();
    n_tests++; if (IReq !== 1'b0 || InstrValid !== 1'b0 || IAddr !== 32'd0) begin n_fail++;
      $display("FAIL rdrop_reset: got ireq=%b vld=%b addr=%h want 0 0 0", IReq, InstrValid, IAddr); end
    reset = 1'b1; IReady = 1'b1;
    tick();
    n_tests++; if (IReq !== 1'b1 || IAddr !== 32'd0) begin n_fail++;
      $display("FAIL rdrop_restart: got ireq=%b addr=%h want 1 0", IReq, IAddr); end
    tick();
    n_tests++; if (InstrValid !== 1'b1 || Instr !== word(32'd0)) begin n_fail++;
      $display("FAIL rdrop_first_word: got vld=%b instr=%h want 1 %h", InstrValid, Instr, word(32'd0)); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_idle_redirect();
    test_drop();
    test_redirect_hit();
    test_wrap();
    test_reset_in_drop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
